axi_apb_multi_bridge: RTL and testbench

//  Single-clock AXI4 slave to APB4 master bridge, fanning out to NUM_SLV APB slaves by address decode.

---
 rtl/axi_apb_multi_bridge.sv | 202 ++++++++++++++++++++
 tb/tb_axi_apb_multi_bridge.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_apb_multi_bridge.sv
// AXI4 slave to APB4 master bridge: one transaction in flight, NUM_SLV-way address decode.
// Optional macro APB_TIMEOUT_EN: complete a beat with SLVERR after TIMEOUT cycles of pready low.
module axi_apb_multi_bridge #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                ID_W      = 4,
  parameter int                NUM_SLV   = 4,
  parameter int                SLV_AW    = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 'h4000_0000,
  parameter int                TIMEOUT   = 255,
  localparam int               STRB_W    = DATA_W/8
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_awvalid,
  output logic                      o_awready,
  input  logic [ADDR_W-1:0]         i_awaddr,
  input  logic [ID_W-1:0]           i_awid,
  input  logic [7:0]                i_awlen,
  input  logic [2:0]                i_awsize,
  input  logic [1:0]                i_awburst,
  input  logic [2:0]                i_awprot,
  input  logic                      i_wvalid,
  output logic                      o_wready,
  input  logic [DATA_W-1:0]         i_wdata,
  input  logic [STRB_W-1:0]         i_wstrb,
  input  logic                      i_wlast,
  output logic                      o_bvalid,
  input  logic                      i_bready,
  output logic [ID_W-1:0]           o_bid,
  output logic [1:0]                o_bresp,
  input  logic                      i_arvalid,
  output logic                      o_arready,
  input  logic [ADDR_W-1:0]         i_araddr,
  input  logic [ID_W-1:0]           i_arid,
  input  logic [7:0]                i_arlen,
  input  logic [2:0]                i_arsize,
  input  logic [1:0]                i_arburst,
  input  logic [2:0]                i_arprot,
  output logic                      o_rvalid,
  input  logic                      i_rready,
  output logic [ID_W-1:0]           o_rid,
  output logic [DATA_W-1:0]         o_rdata,
  output logic [1:0]                o_rresp,
  output logic                      o_rlast,
  output logic [ADDR_W-1:0]         o_paddr,
  output logic [NUM_SLV-1:0]        o_psel,
  output logic                      o_penable,
  output logic                      o_pwrite,
  output logic [DATA_W-1:0]         o_pwdata,
  output logic [STRB_W-1:0]         o_pstrb,
  output logic [2:0]                o_pprot,
  input  logic [NUM_SLV*DATA_W-1:0] i_prdata,
  input  logic [NUM_SLV-1:0]        i_pready,
  input  logic [NUM_SLV-1:0]        i_pslverr
);
  typedef enum logic [2:0] {S_IDLE, S_WDATA, S_SETUP, S_ACCESS, S_WRESP, S_RRESP} state_t;

  state_t            r_state;
  logic              r_last_w, r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [ID_W-1:0]   r_id;
  logic [7:0]        r_len, r_beat;
  logic [2:0]        r_size, r_prot;
  logic [1:0]        r_burst, r_resp;

  logic [ADDR_W-1:0]  w_tgt_addr, w_off, w_sel, w_incr, w_wmask, w_addr_nxt;
  logic               w_miss, w_rdy, w_err, w_tout, w_done, w_last;
  logic [NUM_SLV-1:0] w_onehot;
  logic [DATA_W-1:0]  w_rdata, w_beat_data;
  logic [1:0]         w_beat_resp, w_resp_max;

  // In IDLE the next APB target is the incoming read address; afterwards it is the working address.
  assign w_tgt_addr = (r_state == S_IDLE) ? i_araddr : r_addr;
  assign w_off      = w_tgt_addr - BASE_ADDR;
  assign w_sel      = w_off >> SLV_AW;
  assign w_miss     = (w_tgt_addr < BASE_ADDR) || (w_sel >= ADDR_W'(NUM_SLV));

  always_comb begin
    w_onehot = '0;
    w_rdy    = 1'b0;
    w_err    = 1'b0;
    w_rdata  = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (w_sel == ADDR_W'(i)) begin
        w_onehot[i] = 1'b1;
        w_rdy       = i_pready[i];
        w_err       = i_pslverr[i];
        w_rdata     = i_prdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_incr  = ADDR_W'(1) << r_size;
  assign w_wmask = ((ADDR_W'(r_len) + ADDR_W'(1)) << r_size) - ADDR_W'(1);

  always_comb begin
    case (r_burst)
      2'b00:   w_addr_nxt = r_addr;
      2'b10:   w_addr_nxt = (r_addr & ~w_wmask) | ((r_addr + w_incr) & w_wmask);
      default: w_addr_nxt = r_addr + w_incr;
    endcase
  end

`ifdef APB_TIMEOUT_EN
  logic [15:0] r_tcnt;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                    r_tcnt <= '0;
    else if (r_state != S_ACCESS) r_tcnt <= '0;
    else if (!w_rdy)              r_tcnt <= r_tcnt + 16'd1;
  end
  assign w_tout = (r_state == S_ACCESS) && !w_rdy && (r_tcnt == 16'(TIMEOUT-1));
  logic w_unused;
  assign w_unused = i_wlast;
`else
  assign w_tout = 1'b0;
  logic w_unused;
  assign w_unused = ^{i_wlast, 32'(TIMEOUT)};
`endif

  // A miss completes out of SETUP without ever raising penable.
  assign w_done      = ((r_state == S_SETUP) && w_miss) || ((r_state == S_ACCESS) && (w_rdy || w_tout));
  assign w_beat_resp = (r_state == S_SETUP) ? 2'b11 : (!w_rdy || w_err) ? 2'b10 : 2'b00;
  assign w_beat_data = ((r_state == S_ACCESS) && w_rdy) ? w_rdata : '0;
  assign w_resp_max  = (w_beat_resp > r_resp) ? w_beat_resp : r_resp;
  assign w_last      = (r_beat == r_len);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;  r_last_w <= 1'b0; r_write <= 1'b0; r_addr <= '0; r_id <= '0;
      r_len <= '0; r_beat <= '0; r_size <= '0; r_prot <= '0; r_burst <= '0; r_resp <= '0;
      o_awready <= 1'b0; o_wready <= 1'b0; o_bvalid <= 1'b0; o_bid <= '0; o_bresp <= '0;
      o_arready <= 1'b0; o_rvalid <= 1'b0; o_rid <= '0; o_rdata <= '0; o_rresp <= '0; o_rlast <= 1'b0;
      o_paddr <= '0; o_psel <= '0; o_penable <= 1'b0; o_pwrite <= 1'b0;
      o_pwdata <= '0; o_pstrb <= '0; o_pprot <= '0;
    end else begin
      o_awready <= 1'b0;
      o_arready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Write wins a tie unless it was granted last.
          if (i_awvalid && (!i_arvalid || !r_last_w)) begin
            o_awready <= 1'b1; r_last_w <= 1'b1; r_write <= 1'b1;
            r_addr <= i_awaddr; r_id <= i_awid; r_len <= i_awlen; r_size <= i_awsize;
            r_burst <= i_awburst; r_prot <= i_awprot; r_beat <= '0; r_resp <= '0;
            o_wready <= 1'b1;
            r_state  <= S_WDATA;
          end else if (i_arvalid) begin
            o_arready <= 1'b1; r_last_w <= 1'b0; r_write <= 1'b0;
            r_addr <= i_araddr; r_id <= i_arid; r_len <= i_arlen; r_size <= i_arsize;
            r_burst <= i_arburst; r_prot <= i_arprot; r_beat <= '0; r_resp <= '0;
            o_psel <= w_miss ? '0 : w_onehot; o_paddr <= w_tgt_addr;
            o_pwrite <= 1'b0; o_pstrb <= '0; o_pprot <= i_arprot;
            r_state <= S_SETUP;
          end
        end
        S_WDATA: if (i_wvalid) begin
          o_wready <= 1'b0; o_pwdata <= i_wdata; o_pstrb <= i_wstrb;
          o_psel <= w_miss ? '0 : w_onehot; o_paddr <= w_tgt_addr;
          o_pwrite <= 1'b1; o_pprot <= r_prot;
          r_state <= S_SETUP;
        end
        S_SETUP: if (!w_miss) begin
          o_penable <= 1'b1;
          r_state   <= S_ACCESS;
        end
        S_RRESP: if (i_rready) begin
          o_rvalid <= 1'b0;
          if (o_rlast) r_state <= S_IDLE;
          else begin
            o_psel <= w_miss ? '0 : w_onehot; o_paddr <= w_tgt_addr;
            o_pwrite <= 1'b0; o_pstrb <= '0; o_pprot <= r_prot;
            r_state <= S_SETUP;
          end
        end
        S_WRESP: if (i_bready) begin
          o_bvalid <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: ;
      endcase
      if (w_done) begin
        o_psel <= '0; o_penable <= 1'b0;
        r_addr <= w_addr_nxt; r_beat <= r_beat + 8'd1;
        if (r_write) begin
          r_resp <= w_resp_max;
          if (w_last) begin
            o_bvalid <= 1'b1; o_bresp <= w_resp_max; o_bid <= r_id;
            r_state  <= S_WRESP;
          end else begin
            o_wready <= 1'b1;
            r_state  <= S_WDATA;
          end
        end else begin
          o_rvalid <= 1'b1; o_rdata <= w_beat_data; o_rresp <= w_beat_resp;
          o_rlast  <= w_last; o_rid <= r_id;
          r_state  <= S_RRESP;
        end
      end
    end
  end
endmodule

// File: tb/tb_axi_apb_multi_bridge.sv
// Scoreboard bench for axi_apb_multi_bridge: AXI master tasks plus a behavioural APB slave and monitor.
module tb_axi_apb_multi_bridge;
  localparam int ADDR_W = 32, DATA_W = 32, ID_W = 4, NUM_SLV = 4, STRB_W = 4;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic i_awvalid = 0, o_awready; logic [31:0] i_awaddr = 0; logic [3:0] i_awid = 0;
  logic [7:0] i_awlen = 0; logic [2:0] i_awsize = 0; logic [1:0] i_awburst = 0; logic [2:0] i_awprot = 0;
  logic i_wvalid = 0, o_wready; logic [31:0] i_wdata = 0; logic [3:0] i_wstrb = 0; logic i_wlast = 0;
  logic o_bvalid, i_bready = 1; logic [3:0] o_bid; logic [1:0] o_bresp;
  logic i_arvalid = 0, o_arready; logic [31:0] i_araddr = 0; logic [3:0] i_arid = 0;
  logic [7:0] i_arlen = 0; logic [2:0] i_arsize = 0; logic [1:0] i_arburst = 0; logic [2:0] i_arprot = 0;
  logic o_rvalid, i_rready = 1; logic [3:0] o_rid; logic [31:0] o_rdata; logic [1:0] o_rresp; logic o_rlast;
  logic [31:0] o_paddr; logic [NUM_SLV-1:0] o_psel; logic o_penable, o_pwrite;
  logic [31:0] o_pwdata; logic [3:0] o_pstrb; logic [2:0] o_pprot;
  logic [NUM_SLV*DATA_W-1:0] i_prdata; logic [NUM_SLV-1:0] i_pready, i_pslverr;

  axi_apb_multi_bridge #(.TIMEOUT(8)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_awvalid(i_awvalid), .o_awready(o_awready), .i_awaddr(i_awaddr), .i_awid(i_awid), .i_awlen(i_awlen),
    .i_awsize(i_awsize), .i_awburst(i_awburst), .i_awprot(i_awprot),
    .i_wvalid(i_wvalid), .o_wready(o_wready), .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wlast(i_wlast),
    .o_bvalid(o_bvalid), .i_bready(i_bready), .o_bid(o_bid), .o_bresp(o_bresp),
    .i_arvalid(i_arvalid), .o_arready(o_arready), .i_araddr(i_araddr), .i_arid(i_arid), .i_arlen(i_arlen),
    .i_arsize(i_arsize), .i_arburst(i_arburst), .i_arprot(i_arprot),
    .o_rvalid(o_rvalid), .i_rready(i_rready), .o_rid(o_rid), .o_rdata(o_rdata), .o_rresp(o_rresp), .o_rlast(o_rlast),
    .o_paddr(o_paddr), .o_psel(o_psel), .o_penable(o_penable), .o_pwrite(o_pwrite), .o_pwdata(o_pwdata),
    .o_pstrb(o_pstrb), .o_pprot(o_pprot), .i_prdata(i_prdata), .i_pready(i_pready), .i_pslverr(i_pslverr));

  int errors = 0, checks = 0;
  int wait_n = 0, err_at = 0, apb_seen = 0, busy = 0, wcnt = 0;
  bit mon_en = 1;
  bit grant_q[$];

  typedef struct { logic [31:0] addr; logic wr; logic [31:0] wdata; logic [3:0] strb; logic [3:0] sel; } apb_t;
  typedef struct { logic [31:0] data; logic [1:0] resp; logic last; } rexp_t;
  apb_t apb_q[$];

  // APB slave model: every slave answers with {C0+index, paddr[23:0]} after wait_n wait states.
  for (genvar g = 0; g < NUM_SLV; g++) begin : g_slv
    assign i_prdata[g*DATA_W +: DATA_W] = {8'hC0 + 8'(g), o_paddr[23:0]};
  end
  assign i_pready  = {NUM_SLV{wcnt >= wait_n}};
  assign i_pslverr = {NUM_SLV{(err_at != 0) && (apb_seen == err_at)}};

  always @(posedge clk) begin
    if (o_psel != 0 && !o_penable) wcnt <= 0;
    else if (o_penable)            wcnt <= wcnt + 1;
  end

  always @(negedge clk) begin
    apb_t e;
    if (o_psel != 0) busy++;
    if (i_awvalid && o_awready) grant_q.push_back(1'b1);
    if (i_arvalid && o_arready) grant_q.push_back(1'b0);
    if (o_psel != 0 && !o_penable) begin
      apb_seen++;
      if (mon_en) begin
        checks++;
        if (apb_q.size() == 0) begin
          errors++;
          $display("FAIL apb_unexpected: got paddr=%h psel=%b, required no access", o_paddr, o_psel);
        end else begin
          e = apb_q.pop_front();
          if (o_paddr !== e.addr || o_psel !== e.sel || o_pwrite !== e.wr || o_pstrb !== e.strb ||
              (e.wr && o_pwdata !== e.wdata)) begin
            errors++;
            $display("FAIL apb_setup: got a=%h sel=%b w=%b d=%h s=%h, required a=%h sel=%b w=%b d=%h s=%h",
                     o_paddr, o_psel, o_pwrite, o_pwdata, o_pstrb, e.addr, e.sel, e.wr, e.wdata, e.strb);
          end
        end
      end
    end
  end

  function automatic void decode(input logic [31:0] a, output bit miss, output logic [3:0] oh, output logic [7:0] idx);
    logic [31:0] n;
    miss = 1; oh = '0; idx = '0;
    if (a >= 32'h4000_0000) begin
      n = (a - 32'h4000_0000) / 4096;
      if (n < NUM_SLV) begin miss = 0; idx = n[7:0]; oh = 4'b0001 << n; end
    end
  endfunction

  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] n, win, lo;
    n = 32'd1 << size;
    if (burst == 2'b00) return a;
    if (burst == 2'b10) begin
      win = (32'(len) + 1) * n;
      lo  = a - (a % win);
      return lo + ((a - lo + n) % win);
    end
    return a + n;
  endfunction

  task automatic axi_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [31:0] dbase, input logic [3:0] strb, input int err_beat, input bit sb);
    logic [31:0] a = addr; logic [1:0] resp = 0; bit miss; logic [3:0] oh; logic [7:0] idx; int napb = 0, n;
    for (int b = 0; b <= len; b++) begin
      decode(a, miss, oh, idx);
      if (miss) resp = 2'b11;
      else begin
        napb++;
        if (sb) apb_q.push_back('{a, 1'b1, dbase + b, strb, oh});
        if (napb == err_beat && resp < 2'b10) resp = 2'b10;
      end
      a = next_addr(a, len, size, burst);
    end
    err_at = (err_beat != 0) ? apb_seen + err_beat : 0;
    i_awaddr = addr; i_awid = id; i_awlen = len; i_awsize = size; i_awburst = burst; i_awprot = 3'b010; i_awvalid = 1;
    n = 0; @(negedge clk);
    while (!o_awready && n < 500) begin @(negedge clk); n++; end
    if (!o_awready) begin errors++; checks++; i_awvalid = 0; $display("FAIL aw_handshake: got no awready, required one within 500 cycles"); return; end
    @(posedge clk); #1 i_awvalid = 0;
    for (int b = 0; b <= len; b++) begin
      i_wdata = dbase + b; i_wstrb = strb; i_wlast = (b == len); i_wvalid = 1;
      n = 0; @(negedge clk);
      while (!o_wready && n < 500) begin @(negedge clk); n++; end
      if (!o_wready) begin errors++; checks++; i_wvalid = 0; $display("FAIL w_handshake: got no wready, required one within 500 cycles"); return; end
      @(posedge clk); #1 i_wvalid = 0;
    end
    n = 0; @(negedge clk);
    while (!o_bvalid && n < 2000) begin @(negedge clk); n++; end
    checks++;
    if (!o_bvalid) begin errors++; $display("FAIL b_timeout: got no bvalid, required one within 2000 cycles"); return; end
    if (o_bresp !== resp || o_bid !== id) begin
      errors++; $display("FAIL b_resp: got bresp=%0d bid=%0d, required bresp=%0d bid=%0d", o_bresp, o_bid, resp, id);
    end
    @(posedge clk); #1;
    err_at = 0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input int err_beat, input bit sb, input int rdly, input bit tout);
    rexp_t r_q[$]; rexp_t e; logic [31:0] a = addr, snap; bit miss, stable; logic [3:0] oh; logic [7:0] idx; int napb = 0, n, seen0;
    for (int b = 0; b <= len; b++) begin
      decode(a, miss, oh, idx);
      if (miss) r_q.push_back('{32'h0, 2'b11, b == len});
      else begin
        napb++;
        if (sb) apb_q.push_back('{a, 1'b0, 32'h0, 4'h0, oh});
        if (tout) r_q.push_back('{32'h0, 2'b10, b == len});
        else r_q.push_back('{{8'hC0 + idx, a[23:0]}, (napb == err_beat) ? 2'b10 : 2'b00, b == len});
      end
      a = next_addr(a, len, size, burst);
    end
    err_at = (err_beat != 0) ? apb_seen + err_beat : 0;
    i_rready = (rdly == 0);
    i_araddr = addr; i_arid = id; i_arlen = len; i_arsize = size; i_arburst = burst; i_arprot = 3'b001; i_arvalid = 1;
    n = 0; @(negedge clk);
    while (!o_arready && n < 500) begin @(negedge clk); n++; end
    if (!o_arready) begin errors++; checks++; i_arvalid = 0; $display("FAIL ar_handshake: got no arready, required one within 500 cycles"); return; end
    @(posedge clk); #1 i_arvalid = 0;
    for (int b = 0; b <= len; b++) begin
      n = 0; @(negedge clk);
      while (!o_rvalid && n < 2000) begin @(negedge clk); n++; end
      if (!o_rvalid) begin errors++; checks++; i_rready = 1; $display("FAIL r_timeout: got no rvalid on beat %0d, required one within 2000 cycles", b); return; end
      if (b == 0 && rdly > 0) begin
        snap = o_rdata; seen0 = apb_seen; stable = 1;
        repeat (rdly) begin @(negedge clk); if (!o_rvalid || o_rdata !== snap) stable = 0; end
        checks++;
        if (!stable || apb_seen != seen0) begin
          errors++; $display("FAIL r_hold: got stable=%0d new_setups=%0d, required stable=1 new_setups=0", stable, apb_seen - seen0);
        end
        i_rready = 1;
      end
      e = r_q.pop_front();
      checks++;
      if (o_rdata !== e.data || o_rresp !== e.resp || o_rlast !== e.last || o_rid !== id) begin
        errors++;
        $display("FAIL r_beat%0d: got data=%h resp=%0d last=%b id=%0d, required data=%h resp=%0d last=%b id=%0d",
                 b, o_rdata, o_rresp, o_rlast, o_rid, e.data, e.resp, e.last, id);
      end
      @(posedge clk); #1;
    end
    err_at = 0;
  endtask

  task automatic check_busy(input string name, input int exp);
    @(negedge clk);
    checks++;
    if (busy != exp) begin errors++; $display("FAIL %s_psel_cycles: got %0d, required %0d", name, busy, exp); end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_awready, o_wready, o_bvalid, o_bid, o_bresp, o_arready, o_rvalid, o_rid, o_rdata, o_rresp, o_rlast,
         o_paddr, o_psel, o_penable, o_pwrite, o_pwdata, o_pstrb, o_pprot} !== '0) begin
      errors++; $display("FAIL reset_outputs: got psel=%b paddr=%h rvalid=%b bvalid=%b, required all zero", o_psel, o_paddr, o_rvalid, o_bvalid);
    end
    @(posedge clk); #1 rst = 0;
  endtask

  task automatic test_single_write;
    busy = 0; wait_n = 0;
    axi_write(32'h4000_1004, 4'd5, 8'd0, 3'd2, 2'b01, 32'hA5A5_A5A5, 4'hF, 0, 1);
    check_busy("single_write", 2);
  endtask

  task automatic test_incr_read;
    busy = 0; wait_n = 3;
    axi_read(32'h4000_2000, 4'd9, 8'd3, 3'd2, 2'b01, 0, 1, 0, 0);
    check_busy("incr_read", 20);
    wait_n = 0;
  endtask

  task automatic test_wrap_read;
    axi_read(32'h4000_000C, 4'd3, 8'd3, 3'd2, 2'b10, 0, 1, 0, 0);
  endtask

  task automatic test_fixed_write;
    axi_write(32'h4000_3010, 4'd2, 8'd1, 3'd2, 2'b00, 32'h0BAD_0000, 4'h3, 0, 1);
  endtask

  task automatic test_decerr;
    busy = 0;
    axi_write(32'h4000_5000, 4'd6, 8'd0, 3'd2, 2'b01, 32'h1234_5678, 4'hF, 0, 1);
    check_busy("decerr_write", 0);
    axi_read(32'h3FFF_FFF0, 4'd7, 8'd1, 3'd2, 2'b11, 0, 1, 0, 0);
  endtask

  task automatic test_slverr;
    axi_write(32'h4000_0100, 4'd8, 8'd3, 3'd2, 2'b01, 32'h5000_0000, 4'hF, 2, 1);
    axi_read(32'h4000_3000, 4'd1, 8'd2, 3'd2, 2'b01, 3, 1, 0, 0);
  endtask

  task automatic test_back_to_back;
    rst = 1; @(posedge clk); #1 rst = 0;
    grant_q.delete();
    apb_q.push_back('{32'h4000_0010, 1'b1, 32'h1111_0000, 4'hF, 4'b0001});
    apb_q.push_back('{32'h4000_1020, 1'b0, 32'h0,         4'h0, 4'b0010});
    apb_q.push_back('{32'h4000_2030, 1'b1, 32'h2222_0000, 4'hF, 4'b0100});
    apb_q.push_back('{32'h4000_3040, 1'b0, 32'h0,         4'h0, 4'b1000});
    fork
      begin
        axi_write(32'h4000_0010, 4'd1, 8'd0, 3'd2, 2'b01, 32'h1111_0000, 4'hF, 0, 0);
        axi_write(32'h4000_2030, 4'd3, 8'd0, 3'd2, 2'b01, 32'h2222_0000, 4'hF, 0, 0);
      end
      begin
        axi_read(32'h4000_1020, 4'd2, 8'd0, 3'd2, 2'b01, 0, 0, 5, 0);
        axi_read(32'h4000_3040, 4'd4, 8'd0, 3'd2, 2'b01, 0, 0, 0, 0);
      end
    join
    checks++;
    if (grant_q.size() != 4 || grant_q[0] != 1 || grant_q[1] != 0 || grant_q[2] != 1 || grant_q[3] != 0) begin
      errors++; $display("FAIL grant_order: got %0d grants %p, required W,R,W,R ('{1,0,1,0})", grant_q.size(), grant_q);
    end
  endtask

`ifdef APB_TIMEOUT_EN
  task automatic test_timeout;
    busy = 0; wait_n = 1000;
    axi_read(32'h4000_1000, 4'd12, 8'd0, 3'd2, 2'b01, 0, 1, 0, 1);
    check_busy("timeout", 9);
    wait_n = 0;
  endtask
`endif

  task automatic test_reset_mid;
    int n = 0;
    mon_en = 0; i_rready = 0;
    i_araddr = 32'h4000_1000; i_arid = 4'd7; i_arlen = 8'd3; i_arsize = 3'd2; i_arburst = 2'b01; i_arvalid = 1;
    @(negedge clk);
    while (!o_arready && n < 500) begin @(negedge clk); n++; end
    @(posedge clk); #1 i_arvalid = 0;
    checks++;
    if (o_psel !== 4'b0010) begin errors++; $display("FAIL mid_burst_psel: got %b, required 0010", o_psel); end
    rst = 1; #1;
    checks++;
    if ({o_awready, o_wready, o_bvalid, o_bid, o_bresp, o_arready, o_rvalid, o_rid, o_rdata, o_rresp, o_rlast,
         o_paddr, o_psel, o_penable, o_pwrite, o_pwdata, o_pstrb, o_pprot} !== '0) begin
      errors++; $display("FAIL async_reset: got psel=%b penable=%b paddr=%h, required all zero", o_psel, o_penable, o_paddr);
    end
    @(posedge clk); #1 rst = 0; i_rready = 1;
    apb_q.delete(); mon_en = 1;
    axi_write(32'h4000_2008, 4'd11, 8'd1, 3'd2, 2'b01, 32'hCAFE_0000, 4'hF, 0, 1);
    axi_read(32'h4000_2008, 4'd10, 8'd0, 3'd2, 2'b01, 0, 1, 0, 0);
  endtask

  initial begin
    test_reset;
    test_single_write;
    test_incr_read;
    test_wrap_read;
    test_fixed_write;
    test_decerr;
    test_slverr;
    test_back_to_back;
`ifdef APB_TIMEOUT_EN
    test_timeout;
`endif
    test_reset_mid;
    repeat (3) @(negedge clk);
    checks++;
    if (apb_q.size() != 0) begin errors++; $display("FAIL apb_leftover: got %0d pending accesses, required 0", apb_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish before 50000 cycles");
    $fatal(1, "watchdog");
  end
endmodule
